// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a word-indexed data memory.
// Word-crossing accesses are split over two cycles (or rejected when ALLOW_MISALIGNED=0).
module lsu_align #(
  parameter int   ADDR_W           = 8,
  parameter logic ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t state, state_nx;

  logic              store_p1;
  logic [2:0]        f3_p1;
  logic [1:0]        off_p1;
  logic [ADDR_W-1:0] word_p1;
  logic [31:0]       wdata_p1;
  logic [31:0]       lo_p1;

  logic [1:0]        off;
  logic [4:0]        sh;
  logic [2:0]        end_v;
  logic [2:0]        end_p1;
  logic [5:0]        sh_hi;
  logic [3:0]        strb;
  logic [3:0]        strb_hi;
  logic [ADDR_W-1:0] word;
  logic              supported;
  logic              crossing;
  logic              unused_addr;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [1:0] sz);
    case (sz)
      2'b00:   mask_of = 4'b0001;
      2'b01:   mask_of = 4'b0011;
      default: mask_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = d[7:0];
    h = d[15:0];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    extend = $unsigned(r);
  endfunction

  assign off         = req_addr[1:0];
  assign sh          = {off, 3'b000};
  assign word        = req_addr[ADDR_W+1:2];
  assign end_v       = {1'b0, off} + size_of(req_funct3[1:0]);
  assign crossing    = end_v > 3'd4;
  assign strb        = mask_of(req_funct3[1:0]) << off;
  assign supported   = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
  assign unused_addr = ^{req_addr[31:ADDR_W+2]};

  // Second half: lanes 0..end-5, data shifted down by the bytes already sent.
  assign end_p1  = {1'b0, off_p1} + size_of(f3_p1[1:0]);
  assign strb_hi = (4'b0001 << end_p1[1:0]) - 4'b0001;
  assign sh_hi   = 6'd32 - {1'b0, off_p1, 3'b000};

  assign busy = (state == SECOND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = word;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid && supported && (!crossing || ALLOW_MISALIGNED)) begin
          mem_we    = req_store;
          mem_wstrb = req_store ? strb : 4'b0000;
          mem_wdata = req_wdata << sh;
          if (crossing) state_nx = SECOND;
        end
      end
      SECOND: begin
        mem_addr  = word_p1 + ADDR_W'(1);
        mem_we    = store_p1;
        mem_wstrb = store_p1 ? strb_hi : 4'b0000;
        mem_wdata = wdata_p1 >> sh_hi;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      mem_we    = 1'b0;
      mem_wstrb = 4'b0000;
    end
  end

  // p0 -> p1: latch first half of a split, register load responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      misalign_err <= 1'b0;
      store_p1     <= 1'b0;
      f3_p1        <= 3'd0;
      off_p1       <= 2'd0;
      word_p1      <= '0;
      wdata_p1     <= 32'd0;
      lo_p1        <= 32'd0;
    end else begin
      rsp_valid    <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && supported) begin
            if (!crossing) begin
              if (!req_store) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= extend(mem_rdata >> sh, req_funct3);
              end
            end else if (ALLOW_MISALIGNED) begin
              store_p1 <= req_store;
              f3_p1    <= req_funct3;
              off_p1   <= off;
              word_p1  <= word;
              wdata_p1 <= req_wdata;
              lo_p1    <= mem_rdata >> sh;
            end else begin
              misalign_err <= 1'b1;
            end
          end
        end
        SECOND: begin
          if (!store_p1) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= extend(lo_p1 | (mem_rdata << sh_hi), f3_p1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit directly upstream of the data memory.
- Converts pipeline byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-indexed memory accesses with byte write strobes.
- Sign/zero-extends load data and returns it one cycle later.
- A misaligned access that crosses a word boundary is split into two memory cycles; the pipeline is stalled with `busy` during the split.

Parameters:
- ADDR_W, 8, word-index width of the data memory (256 words).
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = reject them with `misalign_err` and perform no access.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present this cycle.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- busy  output  1  stall; upstream holds its request, but the block ignores req_* while busy.
- rsp_valid  output  1  load result valid (one cycle pulse).
- rsp_rdata  output  32  extended load result.
- misalign_err  output  1  one-cycle pulse, registered.
- mem_addr  output  ADDR_W  word index to memory.
- mem_we  output  1  write enable (memory writes on posedge).
- mem_wstrb  output  4  byte lanes written.
- mem_wdata  output  32  lane-positioned write data.
- mem_rdata  input  32  combinational read of Mem[mem_addr].

Behaviour:
- Reset: state=IDLE; busy=0, rsp_valid=0, rsp_rdata=0, misalign_err=0; all latched request and partial-data registers=0.
- While rst is high, mem_we=0 and mem_wstrb=0.
- Offset definitions: off=req_addr[1:0]; size = 1/2/4 bytes from funct3[1:0]; crossing = off+size>4; word = req_addr[ADDR_W+1:2].
- Unsupported funct3 (011, 110, 111): treated as no request; no access, no response.
- IDLE, req_valid, not crossing:
  - mem_* driven combinationally this cycle; mem_addr=word; strobe = size-mask<<off; wdata = req_wdata<<(8*off).
  - Load: extracted, extended data is registered; rsp_valid=1 on the next cycle (latency 1).
  - Store: no response.
- IDLE, req_valid, crossing, ALLOW_MISALIGNED=1:
  - Cycle 1: access word with lanes off..3. Latch op, funct3, addr and wdata. Load: latch the low (4-off) bytes. Go to SECOND; busy=1 from the next cycle.
  - SECOND: mem_addr=word+1 (wraps modulo 2^ADDR_W). Lanes 0..(off+size-5). Store data is the remaining high bytes at lane 0. Load: combine with the latched low bytes and extend; rsp_valid the next cycle. Return to IDLE; busy deasserts on the same edge.
- Crossing with ALLOW_MISALIGNED=0: no memory access; misalign_err=1 for one cycle starting at the next edge; no rsp_valid.
- busy is registered (state==SECOND); the upstream hold on busy is not combinational.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Async rst asserted in SECOND: abort immediately. The second-half store write does not occur; the first half is already committed. No response is produced.
- rsp_valid and misalign_err never assert in the same cycle.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; mem_we=0 while rst high.
- SW 0xDEADBEEF @0x10 -> mem_addr=4, wstrb=1111, wdata=0xDEADBEEF; then LW @0x10 -> rsp_rdata=0xDEADBEEF one cycle later.
- SB 0x80 @0x13 -> wstrb=1000, wdata=0x80000000; LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080.
- LH @0x13 with Mem[4]=0xAABBCCDD, Mem[5]=0x11223344:
  - cycle 1: mem_addr=4; cycle 2: mem_addr=5, busy=1.
  - rsp_rdata=0x000044AA sign-extended (0x000044AA, bit 15=0).
  - LHU of 0x80FF data -> 0x000080FF.
- SW 0x01020304 @0x3FE:
  - cycle 1: mem_addr=255, wstrb=1100, wdata=0x03040000.
  - cycle 2: mem_addr=0 (wrap), wstrb=0011, wdata=0x00000102.
- ALLOW_MISALIGNED=0, LW @0x02 -> no mem_we, misalign_err pulse 1 cycle, no rsp_valid.
- rst asserted during SECOND of a split SW -> second-half word unchanged, busy=0, next request accepted normally.
